// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU memory subsystem.
package mcpu_pkg;

   // Memory port arbiter FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   // Owner encoding of the memory port.
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LD  = 1'b1;

   // Legal memory read latency range and the counter width that covers it.
   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 4;
   localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-served flag is held by the parent.
module rr_arb2
   import mcpu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   // Lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant = OWN_CPU;
      case (req)
         2'b01:   grant = OWN_CPU;
         2'b10:   grant = OWN_LD;
         2'b11:   grant = (last == OWN_CPU) ? OWN_LD : OWN_CPU;
         default: grant = OWN_CPU;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified instruction/data memory port between the CPU and the
// program loader: latch on grant, one-cycle strobe, fixed-latency read,
// one-cycle ready pulse back to the owner.
module mem_port_arbiter
   import mcpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ready,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned CNT_W = LAT_CNT_W;

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q;
   logic              grant;
   logic              latch_en;
   logic              cap_en;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // Round-robin winner among the current requests.
   rr_arb2 u_rr_arb2 (
      .req   ({ld_req, cpu_req}),
      .last  (last_q),
      .grant (grant)
   );

   // Winner's transfer fields.
   always_comb begin
      win_we    = (grant == OWN_LD) ? ld_we    : cpu_we;
      win_addr  = (grant == OWN_LD) ? ld_addr  : cpu_addr;
      win_wdata = (grant == OWN_LD) ? ld_wdata : cpu_wdata;
   end

   // FSM state and latency counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter update, grant latch and read-capture strobes.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch_en = 1'b0;
      cap_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req || ld_req) begin
               latch_en = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               cap_en  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered strobes and status; the strobe follows the latch by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         cpu_ready <= 1'b0;
         ld_ready  <= 1'b0;
      end else begin
         mem_en    <= latch_en;
         mem_we    <= latch_en & win_we;
         busy      <= (state_d != ST_IDLE);
         cpu_ready <= cap_en & (owner == OWN_CPU);
         ld_ready  <= cap_en & (owner == OWN_LD);
      end
   end

   // Transfer latch, ownership and round-robin history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner     <= OWN_CPU;
         last_q    <= OWN_LD;
      end else begin
         if (latch_en) begin
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            owner     <= grant;
         end
         if (state_q == ST_DONE) begin
            last_q <= owner;
         end
      end
   end

   // Per-owner read data; the non-owner's value is left untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata <= '0;
         ld_rdata  <= '0;
      end else if (cap_en) begin
         if (owner == OWN_CPU) begin
            cpu_rdata <= mem_rdata;
         end else begin
            ld_rdata <= mem_rdata;
         end
      end
   end

endmodule
